// File: rtl/id_decode_skid.sv
// rtl/id_decode_skid.sv - decode-stage register with 2-entry skid buffer and imm-type classification
// Optional: define ID_ILLEGAL_DETECT_EN to flag unlisted opcodes on out_illegal.
module id_decode_skid #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_PC_TAG = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [24:0]     out_raw_src,
  output logic [3:0]      out_imm_type,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [6:0]      out_opcode,
  output logic [XLEN-1:0] out_pc,
  output logic            out_illegal
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [3:0]      imm_type;
    logic            illegal;
  } entry_t;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  localparam entry_t RESET_ENTRY = '{pc: RESET_PC_TAG, instr: 32'h0, imm_type: 4'b1111, illegal: 1'b0};

  state_t state_q, state_d;
  logic   in_ready_q, in_ready_d;
  entry_t main_q, main_d, skid_q, skid_d;
  entry_t in_entry;
  logic   accept, pop;

  always_comb begin
    in_entry          = '{pc: in_pc, instr: in_instr, imm_type: 4'b1111, illegal: 1'b0};
    case (in_instr[6:0])
      7'b0000011, 7'b0010011, 7'b1100111,
      7'b0001111, 7'b1110011:             in_entry.imm_type = 4'b0000;
      7'b0100011:                         in_entry.imm_type = 4'b0001;
      7'b1100011:                         in_entry.imm_type = 4'b0010;
      7'b1101111:                         in_entry.imm_type = 4'b0011;
      7'b0110111, 7'b0010111:             in_entry.imm_type = 4'b0100;
      7'b0110011:                         in_entry.imm_type = 4'b1111;
`ifdef ID_ILLEGAL_DETECT_EN
      default:                            in_entry.illegal  = 1'b1;
`else
      default:                            in_entry.imm_type = 4'b1111;
`endif
    endcase
`ifdef ID_ILLEGAL_DETECT_EN
    // Every listed opcode ends in 2'b11, so compressed encodings are already caught above.
    if (in_instr[1:0] != 2'b11) in_entry.illegal = 1'b1;
`endif
  end

  assign accept    = in_valid && in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign pop       = out_valid && out_ready;
  assign in_ready  = in_ready_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      main_q     <= RESET_ENTRY;
      skid_q     <= RESET_ENTRY;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = ONE;
      ONE: begin
        if (accept && !pop)      state_d = FULL;
        else if (!accept && pop) state_d = EMPTY;
      end
      FULL:    if (pop) state_d = ONE;
      default: state_d = EMPTY;
    endcase
    // A redirect discards everything, including the word offered this cycle.
    if (flush) state_d = EMPTY;
  end

  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    in_ready_d = (state_d != FULL);
    case (state_q)
      EMPTY: if (accept) main_d = in_entry;
      ONE: begin
        if (accept && pop) main_d = in_entry;
        else if (accept)   skid_d = in_entry;
      end
      FULL:    if (pop) main_d = skid_q;
      default: main_d = main_q;
    endcase
  end

  assign out_raw_src  = main_q.instr[31:7];
  assign out_imm_type = main_q.imm_type;
  assign out_rd       = main_q.instr[11:7];
  assign out_rs1      = main_q.instr[19:15];
  assign out_rs2      = main_q.instr[24:20];
  assign out_funct3   = main_q.instr[14:12];
  assign out_funct7   = main_q.instr[31:25];
  assign out_opcode   = main_q.instr[6:0];
  assign out_pc       = out_valid ? main_q.pc : RESET_PC_TAG;
  assign out_illegal  = main_q.illegal;

endmodule

// File: tb/tb_id_decode_skid.sv
// tb/tb_id_decode_skid.sv - randomized and directed check of id_decode_skid against a queue model
module tb_id_decode_skid;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, flush, out_valid, out_ready, out_illegal;
  logic [31:0] in_instr, in_pc, out_pc;
  logic [24:0] out_raw_src;
  logic [3:0]  out_imm_type;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7, out_opcode;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } item_t;
  item_t model_q[$];

  logic [6:0] ops [11] = '{7'h03, 7'h13, 7'h67, 7'h0F, 7'h73, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h33};

  logic [93:0] got_fields;
  assign got_fields = {out_raw_src, out_imm_type, out_rd, out_rs1, out_rs2, out_funct3,
                       out_funct7, out_opcode, out_pc, out_illegal};

  id_decode_skid dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_raw_src(out_raw_src), .out_imm_type(out_imm_type), .out_rd(out_rd), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_funct3(out_funct3), .out_funct7(out_funct7), .out_opcode(out_opcode),
    .out_pc(out_pc), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] exp_imm(input logic [31:0] instr);
    logic [6:0] op = instr[6:0];
    if (op inside {7'h03, 7'h13, 7'h67, 7'h0F, 7'h73}) return 4'h0;
    if (op == 7'h23) return 4'h1;
    if (op == 7'h63) return 4'h2;
    if (op == 7'h6F) return 4'h3;
    if (op inside {7'h37, 7'h17}) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic exp_illegal(input logic [31:0] instr);
`ifdef ID_ILLEGAL_DETECT_EN
    return !(instr[6:0] inside {7'h03, 7'h13, 7'h67, 7'h0F, 7'h73, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h33});
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [93:0] exp_fields(input item_t it);
    return {it.instr[31:7], exp_imm(it.instr), it.instr[11:7], it.instr[19:15], it.instr[24:20],
            it.instr[14:12], it.instr[31:25], it.instr[6:0], it.pc, exp_illegal(it.instr)};
  endfunction

  // One clock: drive at negedge, advance the model at posedge, return at the next negedge.
  task automatic step(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                      input logic ordy, input logic fl);
    logic acc, pp;
    in_valid = v; in_instr = instr; in_pc = pc; out_ready = ordy; flush = fl;
    acc = v && (model_q.size() < 2);
    pp  = ordy && (model_q.size() != 0);
    @(posedge clk);
    if (fl) model_q.delete();
    else begin
      if (pp) void'(model_q.pop_front());
      if (acc) model_q.push_back('{instr, pc});
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
    #12;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    vectors++; if (out_imm_type !== 4'hF) begin miscompares++; $display("FAIL reset_imm_type got %h want f", out_imm_type); end
    vectors++; if (out_pc !== 32'h0) begin miscompares++; $display("FAIL reset_pc got %h want 0", out_pc); end
    vectors++; if ({out_raw_src, out_opcode, out_illegal} !== 33'h0) begin
      miscompares++; $display("FAIL reset_data got %h/%h/%b want 0", out_raw_src, out_opcode, out_illegal); end
    @(negedge clk);
    rst = 1'b0;
    model_q.delete();
  endtask

  task automatic test_addi();
    logic [31:0] ins = 32'h0050_0093;
    step(1'b1, ins, 32'h100, 1'b1, 1'b0);
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL addi_valid got %b want 1", out_valid); end
    vectors++; if ({out_imm_type, out_rd, out_rs1} !== {4'h0, 5'd1, 5'd0}) begin
      miscompares++; $display("FAIL addi_fields got imm %h rd %0d rs1 %0d want 0/1/0", out_imm_type, out_rd, out_rs1); end
    vectors++; if ({out_raw_src, out_pc} !== {ins[31:7], 32'h100}) begin
      miscompares++; $display("FAIL addi_raw_pc got %h %h want %h 100", out_raw_src, out_pc, ins[31:7]); end
    step(1'b0, '0, '0, 1'b1, 1'b0);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL addi_drain got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins [4] = '{32'h0011_2223, 32'h0000_0463, 32'h0080_006F, 32'h1234_50B7};
    logic [3:0]  imm [4] = '{4'h1, 4'h2, 4'h3, 4'h4};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, ins[i], 32'h200 + 32'(4 * i), 1'b1, 1'b0);
      vectors++; if ({out_valid, in_ready, out_imm_type, out_pc} !== {2'b11, imm[i], 32'h200 + 32'(4 * i)}) begin
        miscompares++; $display("FAIL b2b_%0d got v%b r%b imm %h pc %h want v1 r1 imm %h", i, out_valid, in_ready, out_imm_type, out_pc, imm[i]); end
    end
    step(1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_backpressure();
    step(1'b1, 32'h0000_0013, 32'h300, 1'b0, 1'b0);
    vectors++; if ({out_valid, in_ready, out_pc} !== {2'b11, 32'h300}) begin
      miscompares++; $display("FAIL bp_first got v%b r%b pc %h want v1 r1 pc 300", out_valid, in_ready, out_pc); end
    step(1'b1, 32'h0000_0023, 32'h304, 1'b0, 1'b0);
    vectors++; if ({in_ready, out_pc, out_imm_type} !== {1'b0, 32'h300, 4'h0}) begin
      miscompares++; $display("FAIL bp_full got r%b pc %h imm %h want r0 pc 300 imm 0", in_ready, out_pc, out_imm_type); end
    step(1'b1, 32'h0000_0063, 32'h308, 1'b0, 1'b0);
    vectors++; if ({in_ready, out_pc} !== {1'b0, 32'h300}) begin
      miscompares++; $display("FAIL bp_hold got r%b pc %h want r0 pc 300", in_ready, out_pc); end
    step(1'b1, 32'h0000_0063, 32'h308, 1'b1, 1'b0);
    vectors++; if ({out_valid, in_ready, out_pc, out_imm_type} !== {2'b11, 32'h304, 4'h1}) begin
      miscompares++; $display("FAIL bp_second got v%b r%b pc %h imm %h want v1 r1 pc 304 imm 1", out_valid, in_ready, out_pc, out_imm_type); end
    step(1'b1, 32'h0000_0063, 32'h308, 1'b1, 1'b0);
    vectors++; if ({out_valid, out_pc, out_imm_type} !== {1'b1, 32'h308, 4'h2}) begin
      miscompares++; $display("FAIL bp_third got v%b pc %h imm %h want v1 pc 308 imm 2", out_valid, out_pc, out_imm_type); end
    step(1'b0, '0, '0, 1'b1, 1'b0);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drain got %b want 0", out_valid); end
  endtask

  task automatic test_flush();
    step(1'b1, 32'h0000_0013, 32'h400, 1'b0, 1'b0);
    step(1'b1, 32'h0000_0013, 32'h404, 1'b0, 1'b0);
    step(1'b1, 32'h0000_006F, 32'h408, 1'b1, 1'b1);
    vectors++; if ({out_valid, in_ready} !== 2'b01) begin
      miscompares++; $display("FAIL flush_state got v%b r%b want v0 r1", out_valid, in_ready); end
    step(1'b0, '0, '0, 1'b1, 1'b0);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_dropped got %b want 0", out_valid); end
  endtask

  task automatic test_illegal();
`ifdef ID_ILLEGAL_DETECT_EN
    logic ill_exp = 1'b1;
`else
    logic ill_exp = 1'b0;
`endif
    step(1'b1, 32'hFFFF_FFFF, 32'h500, 1'b1, 1'b0);
    vectors++; if ({out_valid, out_imm_type, out_illegal} !== {1'b1, 4'hF, ill_exp}) begin
      miscompares++; $display("FAIL illegal_ffff got v%b imm %h ill %b want v1 imm f ill %b", out_valid, out_imm_type, out_illegal, ill_exp); end
    step(1'b1, 32'h0020_81B3, 32'h504, 1'b1, 1'b0);
    vectors++; if ({out_valid, out_imm_type, out_illegal, out_rd} !== {1'b1, 4'hF, 1'b0, 5'd3}) begin
      miscompares++; $display("FAIL illegal_add got v%b imm %h ill %b rd %0d want v1 imm f ill 0 rd 3", out_valid, out_imm_type, out_illegal, out_rd); end
    step(1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_async_reset();
    step(1'b1, 32'h0000_0013, 32'h600, 1'b0, 1'b0);
    step(1'b1, 32'h0000_0013, 32'h604, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    vectors++; if ({out_valid, in_ready} !== 2'b01) begin
      miscompares++; $display("FAIL async_reset got v%b r%b want v0 r1", out_valid, in_ready); end
    model_q.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      logic [31:0] r;
      vectors++; if (in_ready !== (model_q.size() < 2)) begin
        miscompares++; $display("FAIL rand_in_ready cyc %0d got %b want %b", n, in_ready, model_q.size() < 2); end
      vectors++; if (out_valid !== (model_q.size() != 0)) begin
        miscompares++; $display("FAIL rand_out_valid cyc %0d got %b want %b", n, out_valid, model_q.size() != 0); end
      if (model_q.size() != 0) begin
        vectors++; if (got_fields !== exp_fields(model_q[0])) begin
          miscompares++; $display("FAIL rand_fields cyc %0d got %h want %h", n, got_fields, exp_fields(model_q[0])); end
      end
      r = $urandom();
      if ($urandom_range(0, 7) != 0) r[6:0] = ops[$urandom_range(0, 10)];
      step($urandom_range(0, 3) != 0, r, $urandom(), $urandom_range(0, 9) < 6, $urandom_range(0, 31) == 0);
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_illegal();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
